// File: rtl/seq_divider_if.sv
// seq_divider_if: request/result bundle for seq_divider.
//   master : drives start, in1 (dividend), in2 (divisor);
//            receives quotient, remainder, busy, done, div_by_zero
//   slave  : the divider side of the same signals
interface seq_divider_if #(parameter int WIDTH = 8);
   logic             start;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             busy;
   logic             done;
   logic             div_by_zero;

   modport master (output start, in1, in2,
                   input  quotient, remainder, busy, done, div_by_zero);
   modport slave  (input  start, in1, in2,
                   output quotient, remainder, busy, done, div_by_zero);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, one quotient bit per clock.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : seq_divider_if.slave -- start/in1/in2 request, quotient/remainder
//          results held until the next result, busy, one-cycle done,
//          div_by_zero flag held until the next accepted start
// Latency is WIDTH cycles from the start edge; a zero divisor answers after
// one cycle with quotient all ones and remainder = dividend.
// Optional macro SEQ_DIVIDER_SIGNED_EN: two's complement operands, quotient
// truncated toward zero, remainder carries the dividend's sign.
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   seq_divider_if.slave bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_rem;    // partial remainder (always < divisor)
   logic [WIDTH-1:0] r_dvd;    // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] r_dvs;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_remo;
   logic             r_busy;
   logic             r_done;
   logic             r_dbz;

   logic [WIDTH:0]   w_shift;  // WIDTH+1-bit shifted partial remainder
   logic             w_ge;
   logic [WIDTH-1:0] w_rem_nxt;
   logic [WIDTH-1:0] w_q_nxt;
   logic [WIDTH-1:0] w_mag1;
   logic [WIDTH-1:0] w_mag2;
   logic [WIDTH-1:0] w_q_fin;
   logic [WIDTH-1:0] w_r_fin;

   // Restoring step. When the subtraction succeeds the true difference is
   // below the divisor, so WIDTH-bit modular subtraction is exact.
   assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
   assign w_ge      = (w_shift >= {1'b0, r_dvs});
   assign w_rem_nxt = w_ge ? (w_shift[WIDTH-1:0] - r_dvs) : w_shift[WIDTH-1:0];
   assign w_q_nxt   = {r_dvd[WIDTH-2:0], w_ge};

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic r_qneg;
   logic r_rneg;

   // Negating the most-negative value yields itself, which read unsigned is
   // the correct magnitude; MIN / -1 therefore wraps back to MIN.
   assign w_mag1  = bus.in1[WIDTH-1] ? (~bus.in1 + 1'b1) : bus.in1;
   assign w_mag2  = bus.in2[WIDTH-1] ? (~bus.in2 + 1'b1) : bus.in2;
   assign w_q_fin = r_qneg ? (~w_q_nxt + 1'b1) : w_q_nxt;
   assign w_r_fin = r_rneg ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_qneg <= 1'b0;
         r_rneg <= 1'b0;
      end else if (r_state == S_IDLE && !r_busy && bus.start) begin
         r_qneg <= bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1];
         r_rneg <= bus.in1[WIDTH-1];
      end
   end
`else
   assign w_mag1  = bus.in1;
   assign w_mag2  = bus.in2;
   assign w_q_fin = w_q_nxt;
   assign w_r_fin = w_rem_nxt;
`endif

   // busy set while in IDLE marks a pending divide-by-zero answer; start is
   // not accepted during that cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_rem   <= '0;
         r_dvd   <= '0;
         r_dvs   <= '0;
         r_quot  <= '0;
         r_remo  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_dbz   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == S_IDLE) begin
            if (r_busy) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
               r_dbz  <= 1'b1;
               r_quot <= '1;
               r_remo <= r_dvd;          // raw dividend kept at capture
            end else if (bus.start) begin
               r_busy <= 1'b1;
               r_dbz  <= 1'b0;
               if (bus.in2 == '0) begin
                  r_dvd <= bus.in1;
               end else begin
                  r_state <= S_RUN;
                  r_cnt   <= CNT_INIT;
                  r_rem   <= '0;
                  r_dvd   <= w_mag1;
                  r_dvs   <= w_mag2;
               end
            end
         end else begin
            r_rem <= w_rem_nxt;
            r_dvd <= w_q_nxt;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_quot  <= w_q_fin;
               r_remo  <= w_r_fin;
            end
         end
      end
   end

   assign bus.quotient    = r_quot;
   assign bus.remainder   = r_remo;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.div_by_zero = r_dbz;
endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential restoring divider: the inverse-operation companion to the team's shift-add multiplier. It reuses the same `start`/`done` handshake and operand naming, so the multiplier's bench and control sequencing apply unchanged. It computes one quotient bit per clock and returns the quotient and remainder with a one-cycle `done` pulse. It sits beside the multiplier in `top`-level arithmetic datapaths.

## Interface
- `WIDTH`, 8, operand and result width in bits (≥ 2)
- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous, active-low reset (asserted when 0)
- `start`  input  1  request; sampled only in IDLE
- `in1`  input  WIDTH  dividend
- `in2`  input  WIDTH  divisor
- `quotient`  output  WIDTH  result quotient; registered, held until next result
- `remainder`  output  WIDTH  result remainder; registered, held until next result
- `busy`  output  1  high while a division is in progress
- `done`  output  1  one-cycle pulse when `quotient`/`remainder` become valid
- `div_by_zero`  output  1  set with `done` when `in2` was 0; held until next accepted `start`

## Operation
- States: IDLE, RUN.
- IDLE with `start`=1 at an edge:
  - Capture `in1` and `in2`.
  - Clear `div_by_zero` and set `busy`.
  - Enter RUN with the iteration counter at `WIDTH`-1.
  - Exception: if `in2`=0, go to the divide-by-zero path below instead.
- RUN, each edge (restoring step):
  - Shift {partial remainder, dividend} left by one.
  - Subtract the divisor from the partial remainder.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - The partial remainder is `WIDTH`+1 bits internally. There is no overflow for any unsigned operands.
- Last RUN iteration (counter = 0):
  - Write `quotient` and `remainder`.
  - Pulse `done`, clear `busy`, return to IDLE.
- Divide-by-zero, detected at capture:
  - No RUN cycles; stay in IDLE.
  - On the next edge: `quotient` = all ones, `remainder` = `in1`, `div_by_zero`=1, `done`=1 for one cycle.
  - `busy` is high for that single cycle.
- `start` while `busy`=1 is ignored. Operands are not re-sampled, and the in-flight result is unaffected.
- `in1`/`in2` may change freely after the capture edge.
- Reset asserted at any time, including mid-RUN:
  - Immediately returns to IDLE.
  - Aborts the operation; no `done` is produced.

## Timing
- Reset values: `quotient`=0, `remainder`=0, `busy`=0, `done`=0, `div_by_zero`=0, state IDLE.
- `start` sampled high in IDLE at edge k:
  - `busy`=1 after edge k.
  - `done`=1 and results valid after edge k+`WIDTH`; `busy`=0 after the same edge.
  - `done`=0 after edge k+`WIDTH`+1.
- Latency is `WIDTH` cycles (8 at default). It is independent of operand values.
- Divide-by-zero latency is 1 cycle: `done` after edge k+1.
- Earliest next accepted `start` is at edge k+`WIDTH`+1 (back-to-back throughput: one result per `WIDTH`+1 cycles).
- A `start` held high continuously re-triggers at every IDLE edge. The result from each run remains valid until the next `done`.

## Configuration
- `SEQ_DIVIDER_SIGNED_EN` defined:
  - Operands are two's complement.
  - Magnitudes are taken at capture; signs are applied in the final iteration, so latency is unchanged.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Most-negative ÷ −1 returns quotient = most-negative (0x80 at `WIDTH`=8) and remainder 0, with no flag.
  - Divide-by-zero returns quotient = all ones and remainder = `in1`, as in unsigned mode.
- `SEQ_DIVIDER_SIGNED_EN` undefined: purely unsigned. No sign logic is synthesized.

## Test plan
- Reset then 12 ÷ 4, `start` one cycle → `done` exactly 8 cycles after the start edge; `quotient`=3, `remainder`=0, `div_by_zero`=0.
- 200 ÷ 7, then immediately 49 ÷ 7 at the first legal edge → 28 r 4, then 7 r 0. Each `done` is one cycle wide; `busy` gaps are exactly 1 cycle.
- 13 ÷ 0 → `done` and `div_by_zero` 1 cycle after start; `quotient`=0xFF, `remainder`=13. A following 25 ÷ 5 clears the flag and gives 5 r 0.
- Start 255 ÷ 1, pulse `start` again with 9 ÷ 3 at cycle 3 → ignored; result is 255 r 0 at cycle 8.
- Start 100 ÷ 3, drive `rst`=0 at cycle 4 → all outputs 0 immediately, no `done`. After release, 100 ÷ 3 → 33 r 1.
- With `SEQ_DIVIDER_SIGNED_EN`:
  - −7 ÷ 2 → 0xFD r 0xFF.
  - 7 ÷ −2 → 0xFD r 1.
  - −128 ÷ −1 → 0x80 r 0.
